conv3x3_stream: RTL and testbench
=================================

// Module: conv3x3_stream
// PURPOSE
//  Streaming 3x3 convolution engine, the stage directly upstream of the output-ROM writer.
//  - Fetches a WIDTH x HEIGHT 8-bit image, raster order, from a synchronous input ROM.
//  - Keeps two line buffers and a 3x3 window, and multiplies by a signed kernel.
//  - Emits one (WIDTH-2)x(HEIGHT-2) result per conv_valid pulse: pixel_out, raster order.
// PARAMETERS
//  WIDTH   32  input image width (pixels)
//  HEIGHT  32  input image height (pixels)
//  ADDR_W  10  input ROM address width; 2**ADDR_W >= WIDTH*HEIGHT
// PORTS
//  clk          in   1   clock, rising edge
//  rstb         in   1   reset, asynchronous, active-low
//  start        in   1   one-cycle run request
//  write_ready  in   1   downstream has free space; start accepted only when 1
//  kernel       in   72  9 x signed 8-bit coeffs; [7:0]=k(0,0) ... [71:64]=k(2,2), row-major
//  in_rd        out  1   input ROM read enable
//  in_addr      out  10  input ROM address
//  in_data      in   8   unsigned pixel, valid the cycle after in_rd
//  conv_valid   out  1   pixel_out valid this cycle (one result per pulse)
//  pixel_out    out  32  signed result, sign-extended
//  busy         out  1   high from accepted start until done
//  done         out  1   one-cycle pulse after the last result
// BEHAVIOUR
//  - Reset (async, any time, including mid-run): FSM->IDLE, all counters 0, all outputs 0.
//    Line buffers and window need no reset; validity is tracked by counters only.
//  - FSM: IDLE -> FETCH -> DRAIN -> DONE -> IDLE.
//    - IDLE: start && write_ready -> FETCH, latch kernel, busy=1.
//      start with write_ready=0 is ignored. start in any other state is ignored.
//    - FETCH: in_rd=1 every cycle, in_addr = 0,1,...,WIDTH*HEIGHT-1.
//      Leaves for DRAIN after issuing the last address.
//    - DRAIN: in_rd=0; waits until the last read data has passed the 3-stage datapath.
//    - DONE: done=1 for one cycle, busy=0, -> IDLE.
//  - Arrival tracking: in_data for pixel p arrives 1 cycle after its address.
//    Arrival counters col (0..WIDTH-1) and row (0..HEIGHT-1) wrap col at WIDTH.
//  - Line buffers: lb1 holds row r-1, lb0 holds row r-2, indexed by col.
//    On each arrival: lb0[col]<=lb1[col]; lb1[col]<=in_data.
//    The window shifts left one column, taking {lb0[col], lb1[col], in_data}.
//  - Result for output (i,j) is produced when input (i+2,j+2) arrives (row>=2 && col>=2).
//  - Latency: conv_valid asserts exactly 3 cycles after that in_data cycle.
//    - Stage 1: window register.
//    - Stage 2: 9 products, each {1'b0,pix} * coeff, 17-bit signed.
//    - Stage 3: sum of 9 products, 21-bit signed, sign-extended to 32 bits into pixel_out.
//  - pixel_out(i,j) = sum over a,b of k(a,b)*in(i+a, j+b). No saturation or rounding.
//  - Output cadence: WIDTH-2 consecutive pulses per output row, then a 2-cycle gap (cols 0,1).
//    No output at all during input rows 0 and 1.
//    Total (WIDTH-2)*(HEIGHT-2) pulses, i.e. 900 at the defaults.
//  - Between pulses: conv_valid=0 and pixel_out holds its last value.
//  - done pulses the cycle after the final conv_valid.
//  - Kernel changes while busy have no effect; the latched copy is used.
//  - write_ready dropping mid-run does not stall the engine; it is sampled only at start.
// STRUCTURE
//  - Package conv_pkg: WIDTH/HEIGHT defaults, PIX_W=8, COEF_W=8, PROD_W=17, SUM_W=21, OUT_W=32.
//    It also holds the FSM state encoding (IDLE, FETCH, DRAIN, DONE).
//  - Sub-module conv_line_buffer: WIDTH-deep, 8-bit, single-port, read-before-write.
//    Instantiated twice (lb0, lb1).
//  - Top level: FSM, address/arrival counters, window, MAC pipeline.
// TESTING
//  1. Identity kernel (k(1,1)=1, rest 0), in(p)=p[7:0], start ->
//     900 pulses; result n (raster) = in((n/30+1)*32 + n%30+1), e.g. first=33, last=(990)&255=222.
//  2. All-ones kernel, constant image 10 -> all 900 results = 90.
//  3. All -1 kernel, constant image 255 -> all results = 32'hFFFFF709 (-2295).
//  4. Timing: first conv_valid exactly 3+1+66 cycles after the first FETCH cycle.
//     30-pulse runs with 2-cycle gaps; done one cycle after pulse 900; busy low thereafter.
//  5. start with write_ready=0 -> no in_rd, busy stays 0.
//     start pulsed again while busy -> ignored, still exactly 900 pulses.
//  6. rstb low for 1 cycle mid-FETCH -> all outputs 0 immediately.
//     A fresh start then yields 900 correct results, as in scenario 1.

Source files
------------

// File: rtl/conv_pkg.sv
// Shared widths, default geometry and FSM encoding for the streaming 3x3 convolution engine.
package conv_pkg;

  localparam int DEF_WIDTH  = 32;
  localparam int DEF_HEIGHT = 32;
  localparam int DEF_ADDR_W = 10;

  localparam int PIX_W    = 8;
  localparam int COEF_W   = 8;
  localparam int PROD_W   = 17;
  localparam int SUM_W    = 21;
  localparam int OUT_W    = 32;
  localparam int TAPS     = 9;
  localparam int KERNEL_W = TAPS * COEF_W;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

  // Row-major coefficient k(a,b) out of the packed 72-bit kernel word.
  function automatic logic signed [COEF_W-1:0] coef_at(input logic [KERNEL_W-1:0] k,
                                                       input int a, input int b);
    return k[(a*3 + b)*COEF_W +: COEF_W];
  endfunction

endpackage

// File: rtl/conv3x3_stream_if.sv
// Input-ROM read port and result stream of the convolution engine.
interface conv3x3_stream_if #(
  parameter int ADDR_W = conv_pkg::DEF_ADDR_W
);
  import conv_pkg::*;

  logic              in_rd;
  logic [ADDR_W-1:0] in_addr;
  logic [PIX_W-1:0]  in_data;
  logic              conv_valid;
  logic [OUT_W-1:0]  pixel_out;

  modport master (
    output in_rd, in_addr, conv_valid, pixel_out,
    input  in_data
  );

  modport slave (
    input  in_rd, in_addr, conv_valid, pixel_out,
    output in_data
  );
endinterface

// File: rtl/conv_line_buffer.sv
// One image row of pixels, indexed by column; asynchronous read, so a same-cycle
// write returns the previous row's value (read-before-write).
module conv_line_buffer #(
  parameter int DEPTH  = 32,
  parameter int DATA_W = 8,
  parameter int AW     = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              we,
  input  logic [AW-1:0]     addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [DEPTH];

  assign rdata = mem[addr];

  // NOTE: storage arrays are deliberately not reset; validity comes from the arrival counters.
  always_ff @(posedge clk) begin
    if (we) mem[addr] <= wdata;
  end

endmodule

// File: rtl/conv3x3_stream.sv
// Streaming 3x3 convolution: raster fetch from a synchronous ROM, two line buffers,
// a 3x3 window and a 3-stage multiply/accumulate pipeline.
module conv3x3_stream
  import conv_pkg::*;
#(
  parameter int WIDTH  = DEF_WIDTH,
  parameter int HEIGHT = DEF_HEIGHT,
  parameter int ADDR_W = DEF_ADDR_W
) (
  input  logic                clk,
  input  logic                rstb,
  input  logic                start,
  input  logic                write_ready,
  input  logic [KERNEL_W-1:0] kernel,
  output logic                busy,
  output logic                done,
  conv3x3_stream_if.master    bus
);

  localparam int COL_W = $clog2(WIDTH);
  localparam int ROW_W = $clog2(HEIGHT);
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(WIDTH*HEIGHT - 1);
  localparam logic [COL_W-1:0]  LAST_COL  = COL_W'(WIDTH - 1);
  localparam logic [ROW_W-1:0]  LAST_ROW  = ROW_W'(HEIGHT - 1);

  state_t              state, state_next;
  logic                accept;
  logic [ADDR_W-1:0]   addr;
  logic                rd_valid;
  logic [COL_W-1:0]    col;
  logic [ROW_W-1:0]    row;
  logic [PIX_W-1:0]    lb0_rd, lb1_rd;
  logic [PIX_W-1:0]    win  [3][3];
  logic signed [COEF_W-1:0] coef [3][3];
  logic signed [PROD_W-1:0] prod [3][3];
  logic signed [SUM_W-1:0]  sum;
  logic                v1, v2;

  assign accept = (state == IDLE) && start && write_ready;

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) state <= IDLE;
    else       state <= state_next;
  end

  // NOTE: every output of this block gets a default first, so no path can infer a latch.
  always_comb begin
    state_next = state;
    busy       = 1'b0;
    done       = 1'b0;
    bus.in_rd  = 1'b0;
    unique case (state)
      IDLE:  if (accept) state_next = FETCH;
      FETCH: begin
        busy      = 1'b1;
        bus.in_rd = 1'b1;
        if (addr == LAST_ADDR) state_next = DRAIN;
      end
      DRAIN: begin
        busy = 1'b1;
        // Pipeline empty once the last arrival has left stage 2.
        if (!rd_valid && !v1 && !v2) state_next = DONE;
      end
      DONE: begin
        done       = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  assign bus.in_addr = addr;

  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      addr     <= '0;
      rd_valid <= 1'b0;
      col      <= '0;
      row      <= '0;
    end else begin
      rd_valid <= (state == FETCH);
      if (accept)                addr <= '0;
      else if (state == FETCH)   addr <= (addr == LAST_ADDR) ? '0 : addr + 1'b1;
      if (accept) begin
        col <= '0;
        row <= '0;
      end else if (rd_valid) begin
        if (col == LAST_COL) begin
          col <= '0;
          row <= (row == LAST_ROW) ? '0 : row + 1'b1;
        end else begin
          col <= col + 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (accept) begin
      for (int a = 0; a < 3; a++)
        for (int b = 0; b < 3; b++)
          coef[a][b] <= coef_at(kernel, a, b);
    end
  end

  // lb1 holds row r-1, lb0 row r-2; each arrival ages the column by one row.
  conv_line_buffer #(.DEPTH(WIDTH), .DATA_W(PIX_W)) u_lb0 (
    .clk   (clk),
    .we    (rd_valid),
    .addr  (col),
    .wdata (lb1_rd),
    .rdata (lb0_rd)
  );

  conv_line_buffer #(.DEPTH(WIDTH), .DATA_W(PIX_W)) u_lb1 (
    .clk   (clk),
    .we    (rd_valid),
    .addr  (col),
    .wdata (bus.in_data),
    .rdata (lb1_rd)
  );

  // Stage 1: window shifts left; column 2 is the newest, row 2 the current image row.
  always_ff @(posedge clk) begin
    if (rd_valid) begin
      for (int r = 0; r < 3; r++)
        for (int c = 0; c < 2; c++)
          win[r][c] <= win[r][c+1];
      win[0][2] <= lb0_rd;
      win[1][2] <= lb1_rd;
      win[2][2] <= bus.in_data;
    end
  end

  // Stage 2: unsigned pixel promoted to signed before the multiply.
  always_ff @(posedge clk) begin
    if (v1) begin
      for (int a = 0; a < 3; a++)
        for (int b = 0; b < 3; b++)
          prod[a][b] <= PROD_W'($signed({1'b0, win[a][b]})) * PROD_W'(coef[a][b]);
    end
  end

  always_comb begin
    sum = '0;
    for (int a = 0; a < 3; a++)
      for (int b = 0; b < 3; b++)
        sum = sum + SUM_W'(prod[a][b]);
  end

  // Stage 3 and the validity pipe; pixel_out holds between pulses.
  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      v1             <= 1'b0;
      v2             <= 1'b0;
      bus.conv_valid <= 1'b0;
      bus.pixel_out  <= '0;
    end else begin
      v1             <= rd_valid && (row >= ROW_W'(2)) && (col >= COL_W'(2));
      v2             <= v1;
      bus.conv_valid <= v2;
      if (v2) bus.pixel_out <= OUT_W'(sum);
    end
  end

endmodule

// File: tb/tb_conv3x3_stream.sv
// Scoreboard bench: a direct-sum convolution model fills the expected queue at start,
// a negedge monitor pops and compares on every conv_valid.
module tb_conv3x3_stream;
  import conv_pkg::*;

  localparam int W       = 32;
  localparam int H       = 32;
  localparam int NPIX    = W * H;
  localparam int NOUT    = (W-2) * (H-2);
  localparam int LATENCY = 3 + 1 + 66;

  logic                clk = 1'b0;
  logic                rstb;
  logic                start;
  logic                write_ready;
  logic [KERNEL_W-1:0] kernel;
  logic                busy, done;

  conv3x3_stream_if #(.ADDR_W(10)) bus ();

  conv3x3_stream #(.WIDTH(W), .HEIGHT(H), .ADDR_W(10)) dut (
    .clk         (clk),
    .rstb        (rstb),
    .start       (start),
    .write_ready (write_ready),
    .kernel      (kernel),
    .busy        (busy),
    .done        (done),
    .bus         (bus.master)
  );

  always #5 clk = ~clk;

  logic [7:0]  img [NPIX];
  int          k   [3][3];
  logic [31:0] exp_q [$];
  int          pulse_q [$];
  int          n_cmp = 0;
  int          n_fail = 0;
  int          cyc = 0;
  int          rd_cnt, fetch0, done_cyc;

  // Synchronous input ROM.
  always @(posedge clk) if (bus.in_rd) bus.in_data <= img[bus.in_addr];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
    n_cmp++;
    if (act !== want) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, want);
    end
  endtask

  always @(negedge clk) begin
    if (rstb) begin
      if (bus.in_rd) begin
        rd_cnt++;
        if (fetch0 < 0) fetch0 = cyc;
      end
      if (bus.conv_valid) begin
        pulse_q.push_back(cyc);
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_fail++;
          $display("FAIL extra_pulse: got 0x%0h, expected no pulse", bus.pixel_out);
        end else begin
          check("pixel", bus.pixel_out, exp_q.pop_front());
        end
      end
      if (done && done_cyc < 0) done_cyc = cyc;
    end
  end

  function automatic logic [KERNEL_W-1:0] pack_kernel();
    logic [KERNEL_W-1:0] v = '0;
    for (int a = 0; a < 3; a++)
      for (int b = 0; b < 3; b++)
        v[(a*3+b)*8 +: 8] = 8'(k[a][b]);
    return v;
  endfunction

  task automatic push_expected();
    for (int i = 0; i < H-2; i++)
      for (int j = 0; j < W-2; j++) begin
        int s = 0;
        for (int a = 0; a < 3; a++)
          for (int b = 0; b < 3; b++)
            s += k[a][b] * int'(img[(i+a)*W + j+b]);
        exp_q.push_back(32'(s));
      end
  endtask

  task automatic set_kernel_all(input int v);
    for (int a = 0; a < 3; a++)
      for (int b = 0; b < 3; b++)
        k[a][b] = v;
  endtask

  task automatic clear_tracking();
    rd_cnt   = 0;
    fetch0   = -1;
    done_cyc = -1;
    pulse_q.delete();
  endtask

  task automatic run_frame(input string tag, input bit poke_start);
    int bad;
    clear_tracking();
    push_expected();
    kernel      = pack_kernel();
    start       = 1'b1;
    write_ready = 1'b1;
    @(posedge clk); #1;
    start       = 1'b0;
    write_ready = 1'($urandom_range(0, 1));
    kernel      = {8'($urandom), 32'($urandom), 32'($urandom)};
    check({tag, "_busy_run"}, 32'(busy), 32'd1);
    if (poke_start) begin
      repeat (200) @(posedge clk);
      #1 start = 1'b1; write_ready = 1'b1;
      @(posedge clk); #1 start = 1'b0;
    end
    for (int t = 0; t < 3000 && done_cyc < 0; t++) @(posedge clk);
    repeat (2) @(negedge clk);
    check({tag, "_done_seen"}, 32'(done_cyc >= 0), 32'd1);
    check({tag, "_exp_left"}, 32'(exp_q.size()), 32'd0);
    check({tag, "_pulses"}, 32'(pulse_q.size()), 32'(NOUT));
    check({tag, "_reads"}, 32'(rd_cnt), 32'(NPIX));
    if (pulse_q.size() > 0) begin
      check({tag, "_first_lat"}, 32'(pulse_q[0] - fetch0), 32'(LATENCY));
      check({tag, "_done_gap"}, 32'(done_cyc - pulse_q[pulse_q.size()-1]), 32'd1);
    end
    bad = 0;
    for (int n = 1; n < pulse_q.size(); n++)
      if (pulse_q[n] - pulse_q[n-1] != ((n % (W-2) == 0) ? 3 : 1)) bad++;
    check({tag, "_cadence"}, 32'(bad), 32'd0);
    check({tag, "_busy_after"}, 32'(busy), 32'd0);
    exp_q.delete();
  endtask

  task automatic load_identity();
    set_kernel_all(0);
    k[1][1] = 1;
    for (int p = 0; p < NPIX; p++) img[p] = 8'(p);
  endtask

  task automatic load_random();
    for (int a = 0; a < 3; a++)
      for (int b = 0; b < 3; b++)
        k[a][b] = $signed(8'($urandom));
    for (int p = 0; p < NPIX; p++) img[p] = 8'($urandom);
  endtask

  initial begin
    rstb        = 1'b0;
    start       = 1'b0;
    write_ready = 1'b0;
    kernel      = '0;
    clear_tracking();
    repeat (3) @(posedge clk); #1;
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_in_rd", 32'(bus.in_rd), 32'd0);
    check("rst_in_addr", 32'(bus.in_addr), 32'd0);
    check("rst_valid", 32'(bus.conv_valid), 32'd0);
    check("rst_pixel", bus.pixel_out, 32'd0);
    rstb = 1'b1;
    repeat (2) @(posedge clk); #1;

    load_identity();
    run_frame("identity", 1'b0);

    set_kernel_all(1);
    for (int p = 0; p < NPIX; p++) img[p] = 8'd10;
    run_frame("ones", 1'b0);

    set_kernel_all(-1);
    for (int p = 0; p < NPIX; p++) img[p] = 8'd255;
    run_frame("minus_one", 1'b0);

    // start without downstream space is ignored.
    clear_tracking();
    start = 1'b1; write_ready = 1'b0;
    @(posedge clk); #1 start = 1'b0;
    repeat (30) @(posedge clk); #1;
    check("noready_reads", 32'(rd_cnt), 32'd0);
    check("noready_busy", 32'(busy), 32'd0);

    load_random();
    run_frame("restart_ignored", 1'b1);

    // Reset mid-FETCH after some results have already been produced.
    load_identity();
    clear_tracking();
    push_expected();
    kernel = pack_kernel();
    start = 1'b1; write_ready = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    repeat (100) @(posedge clk);
    #1 rstb = 1'b0;
    #1;
    check("midrst_busy", 32'(busy), 32'd0);
    check("midrst_in_rd", 32'(bus.in_rd), 32'd0);
    check("midrst_in_addr", 32'(bus.in_addr), 32'd0);
    check("midrst_valid", 32'(bus.conv_valid), 32'd0);
    check("midrst_pixel", bus.pixel_out, 32'd0);
    @(posedge clk); #1 rstb = 1'b1;
    exp_q.delete();
    @(posedge clk); #1;
    run_frame("after_reset", 1'b0);

    for (int r = 0; r < 2; r++) begin
      load_random();
      run_frame($sformatf("random%0d", r), 1'b0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
